// File: rtl/fir_interp2_tx_pkg.sv
// Shared definitions for the transmit interpolate-by-2 FIR: sequencer states and pipeline depth.
package fir_interp2_tx_pkg;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StMac0,
    StFlush0,
    StOut0,
    StMac1,
    StFlush1,
    StOut1
  } state_e;

  // Cycles needed to drain the read -> product -> accumulate pipeline after the last address.
  localparam int unsigned FlushCycles = 2;

  function automatic logic is_mac(input state_e s);
    return (s == StMac0) || (s == StMac1);
  endfunction

endpackage

// File: rtl/fir_interp2_coeff_rom.sv
// Prototype coefficient ROM, synchronous read with one clock of latency; address is 2k+p.
module fir_interp2_coeff_rom #(
  parameter int unsigned TAPS        = 64,
  parameter int unsigned COEFF_WIDTH = 18,
  parameter logic [TAPS*COEFF_WIDTH-1:0] COEFFS = '0,
  parameter int unsigned ADDR_WIDTH  = $clog2(TAPS)
) (
  input  logic                          clk,
  input  logic        [ADDR_WIDTH-1:0]  addr,
  output logic signed [COEFF_WIDTH-1:0] coeff
);

  // Coefficient i occupies bits [i*COEFF_WIDTH +: COEFF_WIDTH] of COEFFS.
  always_ff @(posedge clk) begin
    coeff <= COEFFS[32'(addr)*COEFF_WIDTH +: COEFF_WIDTH];
  end

endmodule

// File: rtl/fir_interp2_tx.sv
// Polyphase interpolate-by-2 FIR for I/Q: one shared MAC per rail, two outputs per accepted input.
module fir_interp2_tx
  import fir_interp2_tx_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 16,
  parameter int unsigned COEFF_WIDTH = 18,
  parameter int unsigned TAPS        = 64,
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHIFT       = 17,
  parameter logic [TAPS*COEFF_WIDTH-1:0] COEFFS = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [IN_WIDTH-1:0]  data_in_I,
  input  logic signed [IN_WIDTH-1:0]  data_in_Q,
  input  logic                        strobe_in,
  output logic                        busy,
  output logic signed [OUT_WIDTH-1:0] data_out_I,
  output logic signed [OUT_WIDTH-1:0] data_out_Q,
  output logic                        strobe_out,
  output logic                        overrun
);

  localparam int unsigned Half  = TAPS / 2;
  localparam int unsigned PtrW  = (Half > 1) ? $clog2(Half) : 1;
  localparam int unsigned RomAw = PtrW + 1;
  localparam int unsigned ProdW = IN_WIDTH + COEFF_WIDTH;

  localparam logic signed [ACC_WIDTH:0] RoundBias = (ACC_WIDTH+1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_WIDTH:0] SatMax    = ((ACC_WIDTH+1)'(1) << (OUT_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH:0] SatMin    = -((ACC_WIDTH+1)'(1) << (OUT_WIDTH - 1));

  state_e            state_q, state_d;
  logic [PtrW-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;

  logic                  buf_we;
  logic [PtrW-1:0]       buf_waddr;
  logic [2*IN_WIDTH-1:0] buf_wdata;
  logic [PtrW-1:0]       rd_addr;
  logic [PtrW:0]         rd_sum;
  logic [RomAw-1:0]      rom_addr;
  logic                  phase;
  logic                  acc_clr;
  logic                  out_load;

  logic [2*IN_WIDTH-1:0]   buf_mem [Half];
  logic [2*IN_WIDTH-1:0]   buf_rd_q;
  logic signed [COEFF_WIDTH-1:0] coeff;
  logic signed [IN_WIDTH-1:0]    x_i, x_q;
  logic signed [ProdW-1:0]       prod_i_q, prod_q_q;
  logic signed [ACC_WIDTH-1:0]   acc_i_q, acc_q_q;
  logic                          rd_vld_q, prod_vld_q;
  logic signed [OUT_WIDTH-1:0]   out_i_q, out_q_q;
  logic                          strobe_q, overrun_q;

  function automatic logic [OUT_WIDTH-1:0] round_sat(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH:0] r;
    r = (ACC_WIDTH+1)'(a) + RoundBias;
    r = r >>> SHIFT;
    if (r > SatMax) begin
      round_sat = SatMax[OUT_WIDTH-1:0];
    end else if (r < SatMin) begin
      round_sat = SatMin[OUT_WIDTH-1:0];
    end else begin
      round_sat = r[OUT_WIDTH-1:0];
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    buf_we    = 1'b0;
    buf_waddr = wr_ptr_q;
    buf_wdata = {data_in_Q, data_in_I};
    phase     = 1'b0;
    acc_clr   = 1'b0;
    out_load  = 1'b0;
    unique case (state_q)
      StClear: begin
        buf_we    = 1'b1;
        buf_waddr = cnt_q;
        buf_wdata = '0;
        if (cnt_q == PtrW'(Half - 1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + PtrW'(1);
        end
      end
      StIdle: begin
        if (strobe_in) begin
          buf_we  = 1'b1;
          acc_clr = 1'b1;
          cnt_d   = '0;
          state_d = StMac0;
        end
      end
      StMac0, StMac1: begin
        phase = (state_q == StMac1);
        if (cnt_q == PtrW'(Half - 1)) begin
          cnt_d   = '0;
          state_d = (state_q == StMac0) ? StFlush0 : StFlush1;
        end else begin
          cnt_d = cnt_q + PtrW'(1);
        end
      end
      StFlush0, StFlush1: begin
        if (cnt_q == PtrW'(FlushCycles - 1)) begin
          cnt_d   = '0;
          state_d = (state_q == StFlush0) ? StOut0 : StOut1;
        end else begin
          cnt_d = cnt_q + PtrW'(1);
        end
      end
      StOut0: begin
        // Second OUT0 cycle coincides with the phase-0 strobe and primes phase 1,
        // keeping both phases at the same TAPS/2+4 cadence.
        if (cnt_q == '0) begin
          out_load = 1'b1;
          cnt_d    = PtrW'(1);
        end else begin
          acc_clr = 1'b1;
          cnt_d   = '0;
          state_d = StMac1;
        end
      end
      StOut1: begin
        out_load = 1'b1;
        wr_ptr_d = (wr_ptr_q == PtrW'(Half - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        state_d  = StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  // Newest sample lives at wr_ptr; tap k reads (wr_ptr - k) mod TAPS/2.
  always_comb begin
    rd_sum = {1'b0, wr_ptr_q} + (PtrW+1)'(Half) - {1'b0, cnt_q};
    if (rd_sum >= (PtrW+1)'(Half)) begin
      rd_sum = rd_sum - (PtrW+1)'(Half);
    end
    rd_addr  = rd_sum[PtrW-1:0];
    rom_addr = {cnt_q, phase};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StClear;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[buf_waddr] <= buf_wdata;
    end
    buf_rd_q <= buf_mem[rd_addr];
  end

  fir_interp2_coeff_rom #(
    .TAPS        (TAPS),
    .COEFF_WIDTH (COEFF_WIDTH),
    .COEFFS      (COEFFS),
    .ADDR_WIDTH  (RomAw)
  ) u_coeff_rom (
    .clk   (clk),
    .addr  (rom_addr),
    .coeff (coeff)
  );

  assign x_i = buf_rd_q[IN_WIDTH-1:0];
  assign x_q = buf_rd_q[2*IN_WIDTH-1:IN_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_i_q   <= '0;
      prod_q_q   <= '0;
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      out_i_q    <= '0;
      out_q_q    <= '0;
      strobe_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rd_vld_q   <= is_mac(state_q);
      prod_vld_q <= rd_vld_q;
      prod_i_q   <= x_i * coeff;
      prod_q_q   <= x_q * coeff;
      if (acc_clr) begin
        acc_i_q <= '0;
        acc_q_q <= '0;
      end else if (prod_vld_q) begin
        acc_i_q <= acc_i_q + ACC_WIDTH'(prod_i_q);
        acc_q_q <= acc_q_q + ACC_WIDTH'(prod_q_q);
      end
      if (out_load) begin
        out_i_q <= round_sat(acc_i_q);
        out_q_q <= round_sat(acc_q_q);
      end
      strobe_q <= out_load;
      if (strobe_in && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign busy       = (state_q != StIdle);
  assign data_out_I = out_i_q;
  assign data_out_Q = out_q_q;
  assign strobe_out = strobe_q;
  assign overrun    = overrun_q;

endmodule
